// File: rtl/ring_sequence_checker_if.sv
// Purpose: bundles the ring-word input, the clear strobe and all status
//          outputs of ring_sequence_checker.
// Ports (signals):
//   clr        sync clear of revolution/error bookkeeping
//   onehot_in  NBITS-wide ring word from the sequencer
//   pos        binary index of the hot bit
//   pos_valid  registered word is exactly one-hot
//   locked     checker is tracking a clean rotation
//   err        one-cycle pulse per sequence violation
//   err_sticky held error flag
//   rev_tick   one-cycle pulse per MSB->bit0 wrap while locked
//   rev_count  revolution counter
//   err_count  saturating error counter (only with ERR_COUNT_EN)
// Modports: master drives onehot_in/clr, slave (the checker) drives status.
// Optional feature macro: ERR_COUNT_EN
interface ring_sequence_checker_if #(
  parameter int NBITS = 4,
  parameter int CW    = 8
);
  localparam int PW = (NBITS > 1) ? $clog2(NBITS) : 1;

  logic             clr;
  logic [NBITS-1:0] onehot_in;
  logic [PW-1:0]    pos;
  logic             pos_valid;
  logic             locked;
  logic             err;
  logic             err_sticky;
  logic             rev_tick;
  logic [CW-1:0]    rev_count;
`ifdef ERR_COUNT_EN
  logic [CW-1:0]    err_count;
`endif

  modport master (
`ifdef ERR_COUNT_EN
    input  err_count,
`endif
    output clr, onehot_in,
    input  pos, pos_valid, locked, err, err_sticky, rev_tick, rev_count
  );

  modport slave (
`ifdef ERR_COUNT_EN
    output err_count,
`endif
    input  clr, onehot_in,
    output pos, pos_valid, locked, err, err_sticky, rev_tick, rev_count
  );
endinterface

// File: rtl/ring_sequence_checker.sv
// Purpose: watches the one-hot ring word of the 1->2->4->8 sequencer, decodes
//          the hot position, checks each step is a rotate-left, flags
//          violations and counts completed revolutions.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    ring_sequence_checker_if.slave (clr, onehot_in in; status out)
// Optional feature macro: ERR_COUNT_EN adds a saturating err_count output.
//
// state  | meaning
// IDLE   | no valid ring word seen yet (or upstream held in reset)
// SYNC   | counting consecutive legal steps towards lock
// LOCKED | tracking a clean rotation; violations raise err
// ERROR  | violation seen, waiting for a valid word to resync
module ring_sequence_checker #(
  parameter int NBITS    = 4,
  parameter int CW       = 8,
  parameter int LOCK_CNT = 2
) (
  input logic                   clk,
  input logic                   reset,
  ring_sequence_checker_if.slave bus
);
  localparam int PW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [NBITS-1:0] ONE = NBITS'(1);
  localparam logic [NBITS-1:0] MSB = ONE << (NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [GW-1:0]    good_inc;
  logic [NBITS-1:0] cur_q, prev_q;
  logic [NBITS-1:0] rotl;
  logic             cur_zero, cur_onehot, cur_multi;
  logic             legal, restart;
  logic             err_d, tick_d;
  logic             err_q, tick_q, sticky_q;
  logic [CW-1:0]    rev_q;
  logic [PW-1:0]    pos_c;

  assign rotl       = {prev_q[NBITS-2:0], prev_q[NBITS-1]};
  assign cur_zero   = (cur_q == '0);
  // x & (x-1) clears the lowest set bit; zero result means at most one bit set
  assign cur_onehot = !cur_zero && ((cur_q & (cur_q - ONE)) == '0);
  assign cur_multi  = !cur_zero && !cur_onehot;
  assign legal      = cur_onehot && (cur_q == rotl);
  // a fresh bit0 not preceded by the MSB is an upstream parallel load
  assign restart    = (cur_q == ONE) && (prev_q != MSB);
  assign good_inc   = good_q + GW'(1);

  always_comb begin
    pos_c = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (cur_q[i]) pos_c = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cur_onehot) begin
          state_d = S_SYNC;
          good_d  = '0;
        end
      end
      S_SYNC: begin
        if (cur_zero || cur_multi) begin
          state_d = S_IDLE;
        end else if (legal) begin
          if (good_inc == GW'(LOCK_CNT)) begin
            state_d = S_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end else begin
          good_d = '0;
        end
      end
      S_LOCKED: begin
        if (cur_zero) begin
          state_d = S_IDLE;
        end else if (legal) begin
          tick_d = (prev_q == MSB);
        end else if (restart) begin
          state_d = S_SYNC;
          good_d  = '0;
        end else begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_ERROR: begin
        if (cur_onehot) begin
          state_d = S_SYNC;
          good_d  = '0;
        end else if (cur_zero) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q    <= '0;
      prev_q   <= '0;
      state_q  <= S_IDLE;
      good_q   <= '0;
      err_q    <= 1'b0;
      tick_q   <= 1'b0;
      sticky_q <= 1'b0;
      rev_q    <= '0;
    end else begin
      cur_q   <= bus.onehot_in;
      prev_q  <= cur_q;
      state_q <= state_d;
      good_q  <= good_d;
      err_q   <= err_d;
      tick_q  <= tick_d;
      // clear beats a same-edge tick; a same-edge error beats the clear
      if (bus.clr)     rev_q <= '0;
      else if (tick_d) rev_q <= rev_q + CW'(1);
      if (err_d)        sticky_q <= 1'b1;
      else if (bus.clr) sticky_q <= 1'b0;
    end
  end

`ifdef ERR_COUNT_EN
  logic [CW-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (bus.clr) begin
      err_cnt_q <= err_d ? CW'(1) : '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CW'(1);
    end
  end

  assign bus.err_count = err_cnt_q;
`endif

  assign bus.pos        = pos_c;
  assign bus.pos_valid  = cur_onehot;
  assign bus.locked     = (state_q == S_LOCKED);
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.rev_tick   = tick_q;
  assign bus.rev_count  = rev_q;
endmodule

// File: tb/tb_ring_sequence_checker.sv
// Purpose: self-checking bench for ring_sequence_checker (NBITS=4, CW=8,
//          LOCK_CNT=2). Table of per-edge vectors fed through a scoreboard
//          queue, plus hand sequences for wrap, error saturation and reset.
// Optional feature macro: ERR_COUNT_EN enables err_count checks.
module tb_ring_sequence_checker;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  ring_sequence_checker_if #(.NBITS(4), .CW(8)) bus ();

  ring_sequence_checker #(.NBITS(4), .CW(8), .LOCK_CNT(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic       clr;
    int         pos;
    logic       pv;
    logic       lk;
    logic       er;
    logic       st;
    logic       tk;
    int         rev;
    int         ec;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] in, input logic c, input int p,
                     input logic pv, input logic lk, input logic er,
                     input logic st, input logic tk, input int rev, input int ec);
    vec_t v;
    v.in = in; v.clr = c; v.pos = p; v.pv = pv; v.lk = lk;
    v.er = er; v.st = st; v.tk = tk; v.rev = rev; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [3:0] in, input logic c);
    @(negedge clk);
    bus.onehot_in = in;
    bus.clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    int   ticks;
    int   errs;

    bus.onehot_in = 4'b0000;
    bus.clr       = 1'b0;

    // in clr pos pv lk er st tk rev ec
    add(4'h1,0,0,1,0,0,0,0,0,0);  // 1
    add(4'h2,0,1,1,0,0,0,0,0,0);
    add(4'h4,0,2,1,0,0,0,0,0,0);
    add(4'h8,0,3,1,1,0,0,0,0,0);  // locked after 2->4
    add(4'h1,0,0,1,1,0,0,0,0,0);  // 5
    add(4'h2,0,1,1,1,0,0,1,1,0);  // 8->1 tick
    add(4'h4,0,2,1,1,0,0,0,1,0);
    add(4'h8,0,3,1,1,0,0,0,1,0);
    add(4'h1,0,0,1,1,0,0,0,1,0);
    add(4'h2,0,1,1,1,0,0,1,2,0);  // 10
    add(4'h4,0,2,1,1,0,0,0,2,0);
    add(4'h8,0,3,1,1,0,0,0,2,0);
    add(4'h1,0,0,1,1,0,0,0,2,0);
    add(4'h2,0,1,1,1,0,0,1,3,0);
    add(4'h8,0,3,1,1,0,0,0,3,0);  // 15: 2->8 fed
    add(4'h1,0,0,1,0,1,1,0,3,1);  // err pulse
    add(4'h2,0,1,1,0,0,1,0,3,1);
    add(4'h4,0,2,1,0,0,1,0,3,1);
    add(4'h8,0,3,1,1,0,1,0,3,1);  // relocked, sticky still set
    add(4'h1,1,0,1,1,0,0,0,0,0);  // 20: clr
    add(4'h5,0,0,0,1,0,0,1,1,0);  // multi-hot: pos_valid low
    add(4'h1,0,0,1,0,1,1,0,1,1);  // err one edge later
    add(4'h2,0,1,1,0,0,1,0,1,1);
    add(4'h4,0,2,1,0,0,1,0,1,1);
    add(4'h8,0,3,1,1,0,1,0,1,1);  // 25
    add(4'h1,0,0,1,1,0,1,0,1,1);
    add(4'h2,0,1,1,1,0,1,1,2,1);
    add(4'h4,0,2,1,1,0,1,0,2,1);
    add(4'h8,0,3,1,1,0,1,0,2,1);
    add(4'h1,0,0,1,1,0,1,0,2,1);  // 30
    add(4'h2,0,1,1,1,0,1,1,3,1);
    add(4'h1,0,0,1,1,0,1,0,3,1);  // restart fed
    add(4'h2,0,1,1,0,0,1,0,3,1);  // drop to SYNC, no err
    add(4'h4,0,2,1,0,0,1,0,3,1);
    add(4'h8,0,3,1,1,0,1,0,3,1);  // 35: relocked
    add(4'h1,0,0,1,1,0,1,0,3,1);
    add(4'h0,0,0,0,1,0,1,1,4,1);  // zero fed
    add(4'h0,0,0,0,0,0,1,0,4,1);  // to IDLE, no err
    add(4'h0,0,0,0,0,0,1,0,4,1);
    add(4'h1,0,0,1,0,0,1,0,4,1);  // 40
    add(4'h2,0,1,1,0,0,1,0,4,1);
    add(4'h4,0,2,1,0,0,1,0,4,1);
    add(4'h8,0,3,1,1,0,1,0,4,1);
    add(4'h1,0,0,1,1,0,1,0,4,1);
    add(4'h2,1,1,1,1,0,0,1,0,0);  // 45: clr with tick -> rev 0
    add(4'h8,0,3,1,1,0,0,0,0,0);
    add(4'h1,1,0,1,0,1,1,0,0,1);  // clr with err -> sticky 1
    add(4'h1,0,0,1,0,0,1,0,0,1);

    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst pos", bus.pos, 0);
    chk("rst pos_valid", bus.pos_valid, 0);
    chk("rst locked", bus.locked, 0);
    chk("rst err_sticky", bus.err_sticky, 0);
    chk("rst rev_count", bus.rev_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // table through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.onehot_in = vecs[i].in;
      bus.clr       = vecs[i].clr;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("row%0d scoreboard", i), 0, 1);
      end else begin
        e = sb.pop_front();
        if (e.pv) chk($sformatf("row%0d pos", i), bus.pos, e.pos);
        chk($sformatf("row%0d pos_valid", i), bus.pos_valid, e.pv);
        chk($sformatf("row%0d locked", i), bus.locked, e.lk);
        chk($sformatf("row%0d err", i), bus.err, e.er);
        chk($sformatf("row%0d err_sticky", i), bus.err_sticky, e.st);
        chk($sformatf("row%0d rev_tick", i), bus.rev_tick, e.tk);
        chk($sformatf("row%0d rev_count", i), bus.rev_count, e.rev);
`ifdef ERR_COUNT_EN
        chk($sformatf("row%0d err_count", i), bus.err_count, e.ec);
`endif
      end
    end

    // relock, clear, then 256 clean revolutions
    step(4'h2, 1'b0);
    step(4'h4, 1'b0);
    step(4'h8, 1'b0);
    step(4'h1, 1'b0);
    step(4'h2, 1'b1);
    chk("wrap start rev_count", bus.rev_count, 0);
    chk("wrap start locked", bus.locked, 1);
    chk("wrap start err_sticky", bus.err_sticky, 0);
    ticks = 0;
    errs  = 0;
    for (int g = 0; g < 256; g++) begin
      step(4'h4, 1'b0); ticks += bus.rev_tick; errs += bus.err;
      step(4'h8, 1'b0); ticks += bus.rev_tick; errs += bus.err;
      step(4'h1, 1'b0); ticks += bus.rev_tick; errs += bus.err;
      step(4'h2, 1'b0); ticks += bus.rev_tick; errs += bus.err;
      if (g == 254) chk("wrap rev_count 255", bus.rev_count, 255);
    end
    chk("wrap ticks", ticks, 256);
    chk("wrap rev_count", bus.rev_count, 0);
    chk("wrap errs", errs, 0);

    // 300 injected errors (lock, then 4->2 mismatch)
    errs = 0;
    for (int g = 0; g < 300; g++) begin
      step(4'h4, 1'b0); errs += bus.err;
      step(4'h2, 1'b0); errs += bus.err;
      step(4'h1, 1'b0); errs += bus.err;
      step(4'h2, 1'b0); errs += bus.err;
    end
    chk("inject errs", errs, 300);
    chk("inject err_sticky", bus.err_sticky, 1);
`ifdef ERR_COUNT_EN
    chk("inject err_count", bus.err_count, 255);
`endif

    // relock, then reset mid-revolution with 4'b0100 on the input
    step(4'h4, 1'b0);
    step(4'h8, 1'b0);
    step(4'h1, 1'b0);
    step(4'h2, 1'b0);
    chk("pre-reset locked", bus.locked, 1);
    chk("pre-reset rev_count", bus.rev_count, 1);
    @(negedge clk);
    bus.onehot_in = 4'b0100;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async pos", bus.pos, 0);
    chk("async pos_valid", bus.pos_valid, 0);
    chk("async locked", bus.locked, 0);
    chk("async err", bus.err, 0);
    chk("async err_sticky", bus.err_sticky, 0);
    chk("async rev_tick", bus.rev_tick, 0);
    chk("async rev_count", bus.rev_count, 0);
`ifdef ERR_COUNT_EN
    chk("async err_count", bus.err_count, 0);
`endif
    @(posedge clk);
    #1;
    chk("held pos_valid", bus.pos_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("release+1 pos", bus.pos, 2);
    chk("release+1 pos_valid", bus.pos_valid, 1);
    chk("release+1 locked", bus.locked, 0);
    @(posedge clk);
    #1;
    chk("release+2 locked", bus.locked, 0);
    chk("release+2 err", bus.err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
